// File: rtl/dcache_tag_ctrl_pkg.sv
// Shared definitions for the D-cache tag controller.
// State encoding, address geometry and tag-entry layout helpers.
package dcache_tag_ctrl_pkg;

    localparam int LINE_OFS_W = 4;
    localparam int CADR_W     = 26;
    localparam int LADR_W     = CADR_W - LINE_OFS_W;
    localparam int META_W     = 2;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_LOOKUP = 3'd2,
        S_WBACK  = 3'd3,
        S_FILL   = 3'd4,
        S_UPDATE = 3'd5
    } state_e;

    // Entry is {valid, dirty, tag}; width depends on the index width.
    function automatic int entry_w(input int drw);
        return LADR_W - drw + META_W;
    endfunction

    function automatic int valid_pos(input int drw);
        return entry_w(drw) - 1;
    endfunction

    function automatic int dirty_pos(input int drw);
        return entry_w(drw) - 2;
    endfunction

endpackage

// File: rtl/dcache_tag_ctrl_if.sv
// CPU access and memory-controller handshake bundle of the tag controller.
// The slave side is the controller; the master side drives requests and acks.
interface dcache_tag_ctrl_if;
    import dcache_tag_ctrl_pkg::*;

    logic              cpu_req;
    logic              cpu_wr;
    logic [CADR_W-1:0] cpu_adr;
    logic              cpu_ready;
    logic              cache_busy;
    logic              flush_req;
    logic              mem_wb_req;
    logic              mem_fill_req;
    logic [LADR_W-1:0] mem_line_adr;
    logic              mem_ack;

    modport master (
        output cpu_req, cpu_wr, cpu_adr, flush_req, mem_ack,
        input  cpu_ready, cache_busy, mem_wb_req, mem_fill_req,
        input  mem_line_adr
    );

    modport slave (
        input  cpu_req, cpu_wr, cpu_adr, flush_req, mem_ack,
        output cpu_ready, cache_busy, mem_wb_req, mem_fill_req,
        output mem_line_adr
    );

endinterface

// File: rtl/dcache_tag_ctrl_cmp.sv
// Combinational tag compare: hit, dirty state and victim line address
// for the entry read back from the tag RAM.
module dcache_tag_cmp
    import dcache_tag_ctrl_pkg::*;
#(
    parameter int DRWIDTH = 9
) (
    input  logic [LADR_W-DRWIDTH+META_W-1:0] entry,
    input  logic [LADR_W-DRWIDTH-1:0]        req_tag,
    input  logic [DRWIDTH-1:0]               idx,
    output logic                             hit,
    output logic                             dirty,
    output logic                             wb_need,
    output logic [LADR_W-1:0]                victim_line
);

    localparam int TW = LADR_W - DRWIDTH;

    logic          valid;
    logic [TW-1:0] old_tag;

    assign valid       = entry[valid_pos(DRWIDTH)];
    assign dirty       = entry[dirty_pos(DRWIDTH)];
    assign old_tag     = entry[TW-1:0];
    assign hit         = valid && (old_tag == req_tag);
    assign wb_need     = !hit && valid && dirty;
    assign victim_line = {old_tag, idx};

endmodule

// File: rtl/dcache_tag_ctrl.sv
// D-cache tag-side controller: lookup, writeback/fill sequencing,
// tag rewrite and the post-reset / flush invalidate walk.
module dcache_tag_ctrl
    import dcache_tag_ctrl_pkg::*;
#(
    parameter int DRWIDTH = 9
) (
    input  logic                             clk,
    input  logic                             rst,
    dcache_tag_ctrl_if.slave                 bus,
    output logic [DRWIDTH-1:0]               tag_radr,
    input  logic [LADR_W-DRWIDTH+META_W-1:0] tag_rdata,
    output logic [DRWIDTH-1:0]               tag_wadr,
    output logic [LADR_W-DRWIDTH+META_W-1:0] tag_wdata,
    output logic                             tag_wen
);

    localparam int TW = LADR_W - DRWIDTH;

    state_e              state_q, state_d;
    logic [DRWIDTH-1:0]  cnt_q, cnt_d;
    logic [LADR_W-1:0]   line_q, line_d;
    logic                wr_q, wr_d;
    logic [LADR_W-1:0]   mem_adr_q, mem_adr_d;

    logic [TW-1:0]       req_tag;
    logic [DRWIDTH-1:0]  idx;
    logic                hit, dirty, wb_need;
    logic [LADR_W-1:0]   victim_line;

    logic                ready;
    logic                busy;
    logic                wb_req;
    logic                fill_req;

    assign req_tag = line_q[LADR_W-1:DRWIDTH];
    assign idx     = line_q[DRWIDTH-1:0];

    dcache_tag_cmp #(
        .DRWIDTH (DRWIDTH)
    ) u_cmp (
        .entry       (tag_rdata),
        .req_tag     (req_tag),
        .idx         (idx),
        .hit         (hit),
        .dirty       (dirty),
        .wb_need     (wb_need),
        .victim_line (victim_line)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        wr_d      = wr_q;
        mem_adr_d = mem_adr_q;
        tag_radr  = idx;
        tag_wadr  = idx;
        tag_wdata = '0;
        tag_wen   = 1'b0;
        ready     = 1'b0;
        busy      = 1'b0;
        wb_req    = 1'b0;
        fill_req  = 1'b0;

        unique case (state_q)
            S_INIT: begin
                tag_wen  = 1'b1;
                tag_wadr = cnt_q;
                busy     = 1'b1;
                cnt_d    = cnt_q + DRWIDTH'(1);
                if (&cnt_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                tag_radr = bus.cpu_adr[LINE_OFS_W +: DRWIDTH];
                if (bus.flush_req) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end else if (bus.cpu_req) begin
                    line_d  = bus.cpu_adr[CADR_W-1:LINE_OFS_W];
                    wr_d    = bus.cpu_wr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    ready   = 1'b1;
                    state_d = S_IDLE;
                    // First store to a clean line marks it dirty.
                    if (wr_q && !dirty) begin
                        tag_wen   = 1'b1;
                        tag_wdata = {1'b1, 1'b1, req_tag};
                    end
                end else if (wb_need) begin
                    mem_adr_d = victim_line;
                    state_d   = S_WBACK;
                end else begin
                    mem_adr_d = line_q;
                    state_d   = S_FILL;
                end
            end
            S_WBACK: begin
                wb_req = 1'b1;
                if (bus.mem_ack) begin
                    mem_adr_d = line_q;
                    state_d   = S_FILL;
                end
            end
            S_FILL: begin
                fill_req = 1'b1;
                if (bus.mem_ack) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                tag_wen   = 1'b1;
                tag_wdata = {1'b1, wr_q, req_tag};
                ready     = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase

        // Hold every strobe quiet while reset is asserted.
        if (rst) begin
            tag_wen  = 1'b0;
            ready    = 1'b0;
            wb_req   = 1'b0;
            fill_req = 1'b0;
            busy     = 1'b1;
        end
    end

    assign bus.cpu_ready    = ready;
    assign bus.cache_busy   = busy;
    assign bus.mem_wb_req   = wb_req;
    assign bus.mem_fill_req = fill_req;
    assign bus.mem_line_adr = mem_adr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            line_q    <= '0;
            wr_q      <= 1'b0;
            mem_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            wr_q      <= wr_d;
            mem_adr_q <= mem_adr_d;
        end
    end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Directed bench for dcache_tag_ctrl with a behavioural 1r1w tag RAM.
// Walks reset/INIT, cold fill, hits, dirty writeback, reset abort and flush.
module tb_dcache_tag_ctrl;
    import dcache_tag_ctrl_pkg::*;

    localparam int DRW = 9;
    localparam int EW  = 24 - DRW;
    localparam int TW  = 22 - DRW;

    logic           clk = 1'b0;
    logic           rst;
    logic [DRW-1:0] tag_radr;
    logic [EW-1:0]  tag_rdata;
    logic [DRW-1:0] tag_wadr;
    logic [EW-1:0]  tag_wdata;
    logic           tag_wen;

    int checks = 0;
    int errors = 0;

    dcache_tag_ctrl_if bus ();

    dcache_tag_ctrl #(
        .DRWIDTH (DRW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .tag_radr  (tag_radr),
        .tag_rdata (tag_rdata),
        .tag_wadr  (tag_wadr),
        .tag_wdata (tag_wdata),
        .tag_wen   (tag_wen)
    );

    always #5 clk = ~clk;

    logic [EW-1:0]  ram [2**DRW];
    logic [DRW-1:0] ram_radr_q;

    always_ff @(posedge clk) begin
        if (tag_wen) ram[tag_wadr] <= tag_wdata;
        ram_radr_q <= tag_radr;
    end
    assign tag_rdata = ram[ram_radr_q];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_init();
        for (int i = 0; i < 2**DRW; i++) begin
            chk("init_wen", tag_wen, 1);
            chk("init_wadr", tag_wadr, i);
            chk("init_wdata", tag_wdata, 0);
            chk("init_busy", bus.cache_busy, 1);
            chk("init_fill", bus.mem_fill_req, 0);
            chk("init_wb", bus.mem_wb_req, 0);
            tick();
            bus.mem_ack = 1'b0;
        end
        chk("init_done_busy", bus.cache_busy, 0);
        chk("init_done_wen", tag_wen, 0);
    endtask

    task automatic access(input logic wr, input logic [25:0] adr);
        bus.cpu_req = 1'b1;
        bus.cpu_wr  = wr;
        bus.cpu_adr = adr;
    endtask

    function automatic logic [EW-1:0] ent(input logic v, input logic d,
                                          input logic [25:0] adr);
        logic [TW-1:0] t;
        t = adr[25:4+DRW];
        return {v, d, t};
    endfunction

    initial begin
        rst           = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_adr   = '0;
        bus.flush_req = 1'b0;
        bus.mem_ack   = 1'b0;
        tick();

        chk("rst_wen", tag_wen, 0);
        chk("rst_busy", bus.cache_busy, 1);
        chk("rst_ready", bus.cpu_ready, 0);
        chk("rst_wb", bus.mem_wb_req, 0);
        chk("rst_fill", bus.mem_fill_req, 0);
        rst = 1'b0;
        #1;
        run_init();

        // Cold load: fill then tag write {1,0,0}.
        access(1'b0, 26'h0001230);
        #1;
        chk("cold_radr", tag_radr, 9'h123);
        tick();
        chk("cold_lookup_ready", bus.cpu_ready, 0);
        tick();
        chk("cold_fill_req", bus.mem_fill_req, 1);
        chk("cold_fill_wb", bus.mem_wb_req, 0);
        chk("cold_fill_adr", bus.mem_line_adr, 22'h000123);
        tick();
        chk("cold_fill_hold", bus.mem_fill_req, 1);
        tick();
        chk("cold_fill_hold2", bus.mem_fill_req, 1);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("cold_upd_wen", tag_wen, 1);
        chk("cold_upd_wadr", tag_wadr, 9'h123);
        chk("cold_upd_wdata", tag_wdata, 15'h4000);
        chk("cold_upd_ready", bus.cpu_ready, 1);
        chk("cold_upd_fill", bus.mem_fill_req, 0);
        bus.cpu_req = 1'b0;
        tick();
        chk("cold_idle_ready", bus.cpu_ready, 0);

        // Repeat load hits in the lookup cycle.
        access(1'b0, 26'h0001230);
        tick();
        chk("hit_ready", bus.cpu_ready, 1);
        chk("hit_fill", bus.mem_fill_req, 0);
        chk("hit_wb", bus.mem_wb_req, 0);
        chk("hit_wen", tag_wen, 0);
        bus.cpu_req = 1'b0;
        tick();

        // First store marks the line dirty.
        access(1'b1, 26'h0001234);
        tick();
        chk("st1_ready", bus.cpu_ready, 1);
        chk("st1_wen", tag_wen, 1);
        chk("st1_wadr", tag_wadr, 9'h123);
        chk("st1_wdata", tag_wdata, 15'h6000);
        bus.cpu_req = 1'b0;
        tick();

        access(1'b1, 26'h0001234);
        tick();
        chk("st2_ready", bus.cpu_ready, 1);
        chk("st2_wen", tag_wen, 0);
        bus.cpu_req = 1'b0;
        tick();

        // Conflict load: dirty victim written back, then fill.
        access(1'b0, 26'h0021230);
        tick();
        chk("cf_lookup_ready", bus.cpu_ready, 0);
        tick();
        chk("cf_wb_req", bus.mem_wb_req, 1);
        chk("cf_wb_fill", bus.mem_fill_req, 0);
        chk("cf_wb_adr", bus.mem_line_adr, 22'h000123);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("cf_fill_req", bus.mem_fill_req, 1);
        chk("cf_fill_wb", bus.mem_wb_req, 0);
        chk("cf_fill_adr", bus.mem_line_adr, 22'h002123);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("cf_upd_wen", tag_wen, 1);
        chk("cf_upd_wadr", tag_wadr, 9'h123);
        chk("cf_upd_wdata", tag_wdata, ent(1'b1, 1'b0, 26'h0021230));
        chk("cf_upd_ready", bus.cpu_ready, 1);
        bus.cpu_req = 1'b0;
        tick();

        // Reset in the middle of a fill aborts it.
        access(1'b0, 26'h0041230);
        tick();
        tick();
        chk("ab_fill_req", bus.mem_fill_req, 1);
        chk("ab_fill_adr", bus.mem_line_adr, 22'h004123);
        rst = 1'b1;
        bus.cpu_req = 1'b0;
        tick();
        chk("ab_rst_fill", bus.mem_fill_req, 0);
        chk("ab_rst_busy", bus.cache_busy, 1);
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        #1;
        run_init();

        // Flush beats a simultaneous request.
        access(1'b0, 26'h0001230);
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        bus.cpu_req   = 1'b0;
        chk("fl_ready", bus.cpu_ready, 0);
        chk("fl_fill", bus.mem_fill_req, 0);
        run_init();

        // Line is gone after the flush.
        access(1'b0, 26'h0021230);
        tick();
        chk("post_fl_ready", bus.cpu_ready, 0);
        tick();
        chk("post_fl_fill", bus.mem_fill_req, 1);
        chk("post_fl_wb", bus.mem_wb_req, 0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("post_fl_ready2", bus.cpu_ready, 1);
        bus.cpu_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
